// File: rtl/systolic_array_shift_add_pe.sv
// Shift-and-add PE: y = y_in +/- sum(x << shamt_i) (PASS) or a dot-product accumulator (ACC).
// Latency 1 on y, p_x_delay on x; stall freezes every register, and config loads only while IDLE.
module systolic_array_shift_add_pe #(
  parameter int data_width    = 32,
  parameter int p_shamt_nbits = 3,
  parameter int p_nterms      = 2,
  parameter int p_x_delay     = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              stall,
  input  logic                              in_val,
  input  logic [data_width-1:0]             x_in,
  input  logic [data_width-1:0]             y_in,
  input  logic                              in_last,
  output logic [data_width-1:0]             x_out,
  output logic                              x_out_val,
  output logic [data_width-1:0]             y_out,
  output logic                              y_out_val,
  input  logic                              cfg_en,
  output logic                              cfg_rdy,
  input  logic [p_nterms*p_shamt_nbits-1:0] cfg_shamt,
  input  logic [p_nterms-1:0]               cfg_term_en,
  input  logic                              cfg_neg,
  input  logic                              cfg_mode,
  output logic                              busy
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                            state_q, state_d;
  logic [data_width-1:0]             acc_q, acc_d;
  logic [data_width-1:0]             y_q, y_d;
  logic                              y_vld_q, y_vld_d;
  logic [data_width-1:0]             x_dat_q [p_x_delay];
  logic [data_width-1:0]             x_dat_d [p_x_delay];
  logic [p_x_delay-1:0]              x_vld_q, x_vld_d;
  logic [p_nterms*p_shamt_nbits-1:0] shamt_q, shamt_d;
  logic [p_nterms-1:0]               term_en_q, term_en_d;
  logic                              neg_q, neg_d;
  logic                              mode_q, mode_d;

  logic [data_width-1:0] term_sum;
  logic [data_width-1:0] signed_term;

  // Term sum always uses the registered config, so a same-cycle load affects only later beats.
  always_comb begin
    term_sum = '0;
    for (int i = 0; i < p_nterms; i++) begin
      if (term_en_q[i]) begin
        term_sum = term_sum + (x_in << shamt_q[i*p_shamt_nbits +: p_shamt_nbits]);
      end
    end
    signed_term = neg_q ? ('0 - term_sum) : term_sum;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_vld_d   = y_vld_q;
    x_dat_d   = x_dat_q;
    x_vld_d   = x_vld_q;
    shamt_d   = shamt_q;
    term_en_d = term_en_q;
    neg_d     = neg_q;
    mode_d    = mode_q;

    if (!stall) begin
      // x data only advances with a valid beat so x_out holds across bubbles.
      x_vld_d[0] = in_val;
      if (in_val) x_dat_d[0] = x_in;
      for (int k = 1; k < p_x_delay; k++) begin
        x_vld_d[k] = x_vld_q[k-1];
        if (x_vld_q[k-1]) x_dat_d[k] = x_dat_q[k-1];
      end

      y_vld_d = 1'b0;

      if (cfg_en && state_q == IDLE) begin
        shamt_d   = cfg_shamt;
        term_en_d = cfg_term_en;
        neg_d     = cfg_neg;
        mode_d    = cfg_mode;
      end

      if (in_val) begin
        if (!mode_q) begin
          y_d     = y_in + signed_term;
          y_vld_d = 1'b1;
        end else begin
          case (state_q)
            IDLE: begin
              if (in_last) begin
                y_d     = signed_term;
                y_vld_d = 1'b1;
              end else begin
                acc_d   = signed_term;
                state_d = ACCUM;
              end
            end
            ACCUM: begin
              if (in_last) begin
                y_d     = acc_q + signed_term;
                y_vld_d = 1'b1;
                acc_d   = '0;
                state_d = IDLE;
              end else begin
                acc_d = acc_q + signed_term;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      y_q       <= '0;
      y_vld_q   <= 1'b0;
      x_vld_q   <= '0;
      for (int k = 0; k < p_x_delay; k++) x_dat_q[k] <= '0;
      shamt_q   <= '0;
      term_en_q <= '1;
      neg_q     <= 1'b1;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_vld_q   <= y_vld_d;
      x_vld_q   <= x_vld_d;
      x_dat_q   <= x_dat_d;
      shamt_q   <= shamt_d;
      term_en_q <= term_en_d;
      neg_q     <= neg_d;
      mode_q    <= mode_d;
    end
  end

  assign x_out     = x_dat_q[p_x_delay-1];
  assign x_out_val = x_vld_q[p_x_delay-1];
  assign y_out     = y_q;
  assign y_out_val = y_vld_q;
  assign busy      = (state_q == ACCUM);
  assign cfg_rdy   = (state_q == IDLE) && !stall;

endmodule

// File: tb/tb_systolic_array_shift_add_pe.sv
// Directed bench for systolic_array_shift_add_pe: a 32-bit instance plus an 8-bit one for wrap-around.
module tb_systolic_array_shift_add_pe;

  logic        clk = 1'b0;
  logic        reset, stall, in_val, in_last;
  logic [31:0] x_in, y_in, x_out, y_out;
  logic        x_out_val, y_out_val, cfg_rdy, busy;
  logic [7:0]  x_in8, y_in8, x_out8, y_out8;
  logic        x_out_val8, y_out_val8, cfg_rdy8, busy8;
  logic        cfg_en, cfg_neg, cfg_mode;
  logic [5:0]  cfg_shamt;
  logic [1:0]  cfg_term_en;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_array_shift_add_pe u_dut (
    .clk(clk), .reset(reset), .stall(stall), .in_val(in_val),
    .x_in(x_in), .y_in(y_in), .in_last(in_last),
    .x_out(x_out), .x_out_val(x_out_val), .y_out(y_out), .y_out_val(y_out_val),
    .cfg_en(cfg_en), .cfg_rdy(cfg_rdy), .cfg_shamt(cfg_shamt), .cfg_term_en(cfg_term_en),
    .cfg_neg(cfg_neg), .cfg_mode(cfg_mode), .busy(busy)
  );

  systolic_array_shift_add_pe #(.data_width(8)) u_dut8 (
    .clk(clk), .reset(reset), .stall(stall), .in_val(in_val),
    .x_in(x_in8), .y_in(y_in8), .in_last(in_last),
    .x_out(x_out8), .x_out_val(x_out_val8), .y_out(y_out8), .y_out_val(y_out_val8),
    .cfg_en(cfg_en), .cfg_rdy(cfg_rdy8), .cfg_shamt(cfg_shamt), .cfg_term_en(cfg_term_en),
    .cfg_neg(cfg_neg), .cfg_mode(cfg_mode), .busy(busy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One edge with cfg_en high; term1 shift in sh1, term0 shift in sh0.
  task automatic cfg_load(input logic [2:0] sh1, input logic [2:0] sh0, input logic [1:0] ten,
                          input logic neg, input logic mode);
    cfg_en      = 1'b1;
    cfg_shamt   = {sh1, sh0};
    cfg_term_en = ten;
    cfg_neg     = neg;
    cfg_mode    = mode;
    tick();
    cfg_en      = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; in_val = 1'b1; in_last = 1'b0;
    x_in = 32'd3; y_in = 32'd100; x_in8 = 8'd0; y_in8 = 8'd0;
    cfg_en = 1'b0; cfg_shamt = '0; cfg_term_en = '0; cfg_neg = 1'b0; cfg_mode = 1'b0;
    tick(); tick();
    chk("rst_y", y_out, 32'd0);
    chk("rst_yv", {31'd0, y_out_val}, 32'd0);
    chk("rst_x", x_out, 32'd0);
    chk("rst_xv", {31'd0, x_out_val}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_y8", {24'd0, y_out8}, 32'd0);

    // Default config: 100 - (3 + 3) = 94.
    reset = 1'b0;
    tick();
    chk("dflt_y", y_out, 32'd94);
    chk("dflt_yv", {31'd0, y_out_val}, 32'd1);
    chk("dflt_xv_early", {31'd0, x_out_val}, 32'd0);
    in_val = 1'b0;
    tick();
    chk("dflt_yv_drop", {31'd0, y_out_val}, 32'd0);
    chk("dflt_y_hold", y_out, 32'd94);
    chk("dflt_x", x_out, 32'd3);
    chk("dflt_xv", {31'd0, x_out_val}, 32'd1);
    tick();
    chk("x_bubble_v", {31'd0, x_out_val}, 32'd0);
    chk("x_bubble_hold", x_out, 32'd3);

    // Beat in the load cycle still sees the default config: 0 - 10.
    in_val = 1'b1; x_in = 32'd5; y_in = 32'd0;
    cfg_load(3'd3, 3'd1, 2'b11, 1'b0, 1'b0);
    chk("old_cfg_y", y_out, 32'hFFFF_FFF6);
    tick();
    chk("two_terms_y", y_out, 32'd50);
    in_val = 1'b0;
    cfg_load(3'd3, 3'd1, 2'b01, 1'b0, 1'b0);
    chk("cfg_cycle_yv", {31'd0, y_out_val}, 32'd0);
    in_val = 1'b1;
    tick();
    chk("one_term_y", y_out, 32'd10);
    in_val = 1'b0;
    cfg_load(3'd3, 3'd1, 2'b00, 1'b0, 1'b0);
    in_val = 1'b1; y_in = 32'd7;
    tick();
    chk("no_term_y", y_out, 32'd7);
    in_val = 1'b0;
    tick(); tick();
    chk("pre_stall_x", x_out, 32'd5);

    // Stall: 1 + 16 + 4 = 21 must freeze with both valids while inputs churn.
    cfg_load(3'd3, 3'd1, 2'b11, 1'b0, 1'b0);
    in_val = 1'b1; x_in = 32'd2; y_in = 32'd1;
    tick();
    chk("stall_pre_y", y_out, 32'd21);
    stall = 1'b1; x_in = 32'd9; y_in = 32'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_y", y_out, 32'd21);
      chk("stall_yv", {31'd0, y_out_val}, 32'd1);
      chk("stall_x", x_out, 32'd5);
      chk("stall_xv", {31'd0, x_out_val}, 32'd0);
      chk("stall_cfg_rdy", {31'd0, cfg_rdy}, 32'd0);
    end
    stall = 1'b0; in_val = 1'b0;
    tick();
    chk("resume_yv", {31'd0, y_out_val}, 32'd0);
    chk("resume_y", y_out, 32'd21);
    chk("resume_x", x_out, 32'd2);
    chk("resume_xv", {31'd0, x_out_val}, 32'd1);

    // Accumulate 1 + 2 + 3 with an ignored config attempt mid-vector.
    cfg_load(3'd0, 3'd0, 2'b01, 1'b0, 1'b1);
    in_val = 1'b1; x_in = 32'd1; in_last = 1'b0;
    tick();
    chk("acc_busy1", {31'd0, busy}, 32'd1);
    chk("acc_yv1", {31'd0, y_out_val}, 32'd0);
    chk("acc_cfg_rdy", {31'd0, cfg_rdy}, 32'd0);
    x_in = 32'd2;
    cfg_load(3'd2, 3'd2, 2'b11, 1'b1, 1'b0);
    chk("acc_busy2", {31'd0, busy}, 32'd1);
    x_in = 32'd3; in_last = 1'b1;
    tick();
    chk("acc_y", y_out, 32'd6);
    chk("acc_yv", {31'd0, y_out_val}, 32'd1);
    chk("acc_busy_end", {31'd0, busy}, 32'd0);
    in_val = 1'b0; in_last = 1'b0;
    tick();
    chk("acc_pulse", {31'd0, y_out_val}, 32'd0);
    chk("acc_y_hold", y_out, 32'd6);

    // Reset mid-vector drops the partial sum.
    in_val = 1'b1; x_in = 32'd4;
    tick(); tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; in_val = 1'b0;
    tick();
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_y", y_out, 32'd0);
    reset = 1'b0;
    cfg_load(3'd0, 3'd0, 2'b01, 1'b0, 1'b1);
    in_val = 1'b1; x_in = 32'd2; in_last = 1'b1;
    tick();
    chk("single_y", y_out, 32'd2);
    chk("single_yv", {31'd0, y_out_val}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd0);
    in_val = 1'b0; in_last = 1'b0;

    // 8-bit wrap: 0x80 << 1 vanishes; 0 - 1 wraps to 0xFF.
    cfg_load(3'd0, 3'd1, 2'b01, 1'b0, 1'b0);
    in_val = 1'b1; x_in8 = 8'h80; y_in8 = 8'h33;
    tick();
    chk("wrap_shift_y8", {24'd0, y_out8}, 32'h33);
    chk("wrap_shift_yv8", {31'd0, y_out_val8}, 32'd1);
    in_val = 1'b0;
    cfg_load(3'd0, 3'd0, 2'b01, 1'b1, 1'b0);
    in_val = 1'b1; x_in8 = 8'h01; y_in8 = 8'h00;
    tick();
    chk("wrap_neg_y8", {24'd0, y_out8}, 32'hFF);
    in_val = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
